pipeline_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the four-stage (fetch/decode/execute/writeback) 16-bit CPU pipeline. Watches the instruction registers of decode, execute and writeback and tells the datapath when to hold, bubble or forward. Handles two cases: RAW dependences between in-flight instructions, and the multi-cycle MUL occupying execute. Sits beside the pipeline stage registers; all its outputs are qualified by the same advance enable that clocks the stages.

---
 rtl/cpu_pkg.sv | 64 ++++++
 rtl/mul_sequencer.sv | 71 +++++++
 rtl/pipeline_hazard_ctrl.sv | 117 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU pipeline: opcodes, instruction field
// positions, forwarding selects and operand-usage decode helpers.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_ADDI = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_ANDI = 4'd7;
    localparam logic [3:0] OP_ORI  = 4'd8;
    localparam logic [3:0] OP_XORI = 4'd9;
    localparam logic [3:0] OP_SHLI = 4'd10;
    localparam logic [3:0] OP_SUBI = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;

    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam int RD_HI = 11;
    localparam int RD_LO = 8;
    localparam int RS_HI = 7;
    localparam int RS_LO = 4;
    localparam int RT_HI = 3;
    localparam int RT_LO = 0;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_EX = 2'd1,
        FWD_WB = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_RUN  = 2'd1,
        MS_LAST = 2'd2
    } mul_state_e;

    function automatic logic is_writer(input logic [3:0] op);
        return (op != OP_NOP) && (op <= OP_MUL);
    endfunction

    function automatic logic reads_rs(input logic [3:0] op);
        logic r;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL: r = 1'b1;
            default:                                       r = 1'b0;
        endcase
        return r;
    endfunction

    // Immediate-form ops carry an immediate in [7:4] but still read rt.
    function automatic logic reads_rt(input logic [3:0] op);
        logic r;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL:          r = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SHLI, OP_SUBI:    r = 1'b1;
            default:                                                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mul_sequencer.sv
// Tracks how long a MUL has occupied execute; holds execute until its last
// advance and flags the cycle its result is valid.
module mul_sequencer
    import cpu_pkg::*;
#(
    parameter int MUL_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    input  logic [3:0] op_e,
    output logic       hold_e,
    output logic       mul_done
);

    localparam logic [3:0] LAST_C = 4'(MUL_LAT - 1);

    logic [3:0] mcnt_r;
    logic [3:0] mcnt_nxt_s;
    logic       is_mul_s;
    mul_state_e state_s;

    // State decode, hold/done outputs and next count
    always_comb begin
        is_mul_s   = (op_e == OP_MUL);
        hold_e     = 1'b0;
        mul_done   = 1'b0;
        mcnt_nxt_s = mcnt_r;
        // LAST is tested first so that MUL_LAT=1 never holds
        if (mcnt_r == LAST_C) begin
            state_s = MS_LAST;
        end else if (mcnt_r == 4'd0) begin
            state_s = MS_IDLE;
        end else begin
            state_s = MS_RUN;
        end
        case (state_s)
            MS_IDLE, MS_RUN: begin
                hold_e   = is_mul_s;
                mul_done = 1'b0;
            end
            MS_LAST: begin
                hold_e   = 1'b0;
                mul_done = is_mul_s;
            end
            default: begin
                hold_e   = 1'b0;
                mul_done = 1'b0;
            end
        endcase
        if (adv) begin
            if (hold_e) begin
                mcnt_nxt_s = mcnt_r + 4'd1;
            end else begin
                mcnt_nxt_s = 4'd0;
            end
        end else begin
            mcnt_nxt_s = mcnt_r;
        end
    end

    // Occupancy counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt_r <= 4'd0;
        end else begin
            mcnt_r <= mcnt_nxt_s;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 4-stage pipeline: RAW detection, MUL hold, stall stats.
// Define HAZ_FWD_EN to resolve RAW hazards by forwarding instead of interlocking.
module pipeline_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int MUL_LAT     = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   adv,
    input  logic [15:0]            ird,
    input  logic [15:0]            ire,
    input  logic [15:0]            irw,
    output logic                   hold_fd,
    output logic                   hold_e,
    output logic                   bubble_e,
    output logic                   bubble_w,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b,
    output logic                   mul_done,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic [3:0] op_d_s, op_e_s, op_w_s;
    logic [3:0] rs_d_s, rt_d_s, rd_e_s, rd_w_s;
    logic       rd_a_s, rd_b_s, wr_e_s, wr_w_s;
    logic       a_me_s, a_mw_s, b_me_s, b_mw_s;
    logic       raw_stall_s, hold_e_s, hold_fd_s;
    fwd_sel_e   fwd_a_s, fwd_b_s;
    logic [STALL_CNT_W-1:0] stall_cnt_r;
    logic       unused_s;

    assign op_d_s   = ird[OP_HI:OP_LO];
    assign rs_d_s   = ird[RS_HI:RS_LO];
    assign rt_d_s   = ird[RT_HI:RT_LO];
    assign op_e_s   = ire[OP_HI:OP_LO];
    assign rd_e_s   = ire[RD_HI:RD_LO];
    assign op_w_s   = irw[OP_HI:OP_LO];
    assign rd_w_s   = irw[RD_HI:RD_LO];
    assign unused_s = ^{ird[RD_HI:RD_LO], ire[RS_HI:RT_LO], irw[RS_HI:RT_LO]};

    mul_sequencer #(
        .MUL_LAT (MUL_LAT)
    ) u_mul_seq (
        .clk      (clk),
        .rst      (rst),
        .adv      (adv),
        .op_e     (op_e_s),
        .hold_e   (hold_e_s),
        .mul_done (mul_done)
    );

    // Source-versus-destination matching for the decode operands
    always_comb begin
        rd_a_s = reads_rs(op_d_s);
        rd_b_s = reads_rt(op_d_s);
        wr_e_s = is_writer(op_e_s);
        wr_w_s = is_writer(op_w_s);
        a_me_s = rd_a_s && wr_e_s && (rd_e_s == rs_d_s);
        a_mw_s = rd_a_s && wr_w_s && (rd_w_s == rs_d_s);
        b_me_s = rd_b_s && wr_e_s && (rd_e_s == rt_d_s);
        b_mw_s = rd_b_s && wr_w_s && (rd_w_s == rt_d_s);
    end

`ifdef HAZ_FWD_EN
    // Forwarding selects; the younger producer in execute wins
    always_comb begin
        raw_stall_s = 1'b0;
        if (a_me_s) begin
            fwd_a_s = FWD_EX;
        end else if (a_mw_s) begin
            fwd_a_s = FWD_WB;
        end else begin
            fwd_a_s = FWD_RF;
        end
        if (b_me_s) begin
            fwd_b_s = FWD_EX;
        end else if (b_mw_s) begin
            fwd_b_s = FWD_WB;
        end else begin
            fwd_b_s = FWD_RF;
        end
    end
`else
    // Interlock: decode waits until no producer remains in execute or writeback
    always_comb begin
        fwd_a_s     = FWD_RF;
        fwd_b_s     = FWD_RF;
        raw_stall_s = a_me_s | a_mw_s | b_me_s | b_mw_s;
    end
`endif

    // Pipeline control outputs; a MUL hold freezes decode rather than bubbling it
    always_comb begin
        hold_fd_s = hold_e_s | raw_stall_s;
        hold_fd   = hold_fd_s;
        hold_e    = hold_e_s;
        bubble_w  = hold_e_s;
        bubble_e  = raw_stall_s & ~hold_e_s;
        fwd_a     = fwd_a_s;
        fwd_b     = fwd_b_s;
        stall_cnt = stall_cnt_r;
    end

    // Saturating count of advances spent with fetch/decode held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= '0;
        end else if (adv && hold_fd_s && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, directed MUL/RAW
// sequences and a random instruction stream checked against a pipeline model.
module tb_pipeline_hazard_ctrl;

    localparam int MUL_LAT = 4;
`ifdef HAZ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk, rst, adv;
    logic [15:0] ird, ire, irw;
    logic        hold_fd, hold_e, bubble_e, bubble_w, mul_done;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    int n_pass, n_total;
    int mul_age;
    int stall_m;
    bit rand_mode;
    logic obs_hold_e, obs_mul_done;
    logic [15:0] fetch_q[$];

    pipeline_hazard_ctrl #(.MUL_LAT(MUL_LAT), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .adv(adv), .ird(ird), .ire(ire), .irw(irw),
        .hold_fd(hold_fd), .hold_e(hold_e), .bubble_e(bubble_e), .bubble_w(bubble_w),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mul_done(mul_done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [15:0] d, e, w;
        logic        he, raw;
        logic [1:0]  fa, fb;
    } vec_t;

    typedef struct {
        logic hold_fd, hold_e, bubble_e, bubble_w, mul_done, stall;
        logic [1:0] fa, fb;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else n_pass++;
    endtask

    // Reference model: fields by plain arithmetic, rules straight from the ISA table
    function automatic int m_op(logic [15:0] i);  return int'(i) / 4096;        endfunction
    function automatic int m_rd(logic [15:0] i);  return (int'(i) / 256) % 16; endfunction
    function automatic int m_rs(logic [15:0] i);  return (int'(i) / 16) % 16;  endfunction
    function automatic int m_rt(logic [15:0] i);  return int'(i) % 16;         endfunction
    function automatic bit m_writes(logic [15:0] i); return m_op(i) >= 1 && m_op(i) <= 12; endfunction

    function automatic int m_sel(bit used, int src, logic [15:0] e, logic [15:0] w);
        if (!used) return 0;
        if (m_writes(e) && m_rd(e) == src) return 1;
        if (m_writes(w) && m_rd(w) == src) return 2;
        return 0;
    endfunction

    function automatic exp_t model(logic [15:0] d, logic [15:0] e, logic [15:0] w, int age);
        exp_t x;
        int od, sa, sb;
        bit use_rs, use_rt;
        od     = m_op(d);
        use_rs = (od == 1 || od == 2 || od == 4 || od == 5 || od == 6 || od == 12);
        use_rt = (od >= 1 && od <= 12);
        sa = m_sel(use_rs, m_rs(d), e, w);
        sb = m_sel(use_rt, m_rt(d), e, w);
        x.hold_e   = (m_op(e) == 12) && (age < MUL_LAT - 1);
        x.mul_done = (m_op(e) == 12) && (age == MUL_LAT - 1);
        x.stall    = !FWD && (sa != 0 || sb != 0);
        x.fa       = FWD ? 2'(sa) : 2'd0;
        x.fb       = FWD ? 2'(sb) : 2'd0;
        x.hold_fd  = x.hold_e || x.stall;
        x.bubble_e = x.stall && !x.hold_e;
        x.bubble_w = x.hold_e;
        return x;
    endfunction

    function automatic logic [15:0] rnd_instr();
        return {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                4'($urandom_range(0, 3)), 4'($urandom_range(0, 7))};
    endfunction

    function automatic logic [15:0] fetch();
        if (fetch_q.size() > 0) return fetch_q.pop_front();
        if (rand_mode) return rnd_instr();
        return 16'h0000;
    endfunction

    task automatic do_reset();
        adv = 1'b0; rst = 1'b1;
        ird = 16'h0000; ire = 16'h0000; irw = 16'h0000;
        fetch_q.delete(); rand_mode = 1'b0; mul_age = 0; stall_m = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One pipeline cycle: check DUT against the model, then move the modelled stages
    task automatic step(input logic a);
        exp_t x;
        @(negedge clk);
        adv = a;
        #1;
        x = model(ird, ire, irw, mul_age);
        check("hold_fd",   hold_fd,   x.hold_fd);
        check("hold_e",    hold_e,    x.hold_e);
        check("bubble_e",  bubble_e,  x.bubble_e);
        check("bubble_w",  bubble_w,  x.bubble_w);
        check("mul_done",  mul_done,  x.mul_done);
        check("fwd_a",     fwd_a,     x.fa);
        check("fwd_b",     fwd_b,     x.fb);
        check("stall_cnt", stall_cnt, stall_m);
        obs_hold_e   = hold_e;
        obs_mul_done = mul_done;
        @(posedge clk);
        #1;
        adv = 1'b0;
        if (a) begin
            if (x.hold_fd && stall_m != 65535) stall_m++;
            if (x.hold_e) begin
                mul_age++;
                irw = 16'h0000;
            end else begin
                irw = ire;
                mul_age = 0;
                if (x.stall) begin
                    ire = 16'h0000;
                end else begin
                    ire = ird;
                    ird = fetch();
                end
            end
        end
    endtask

    task automatic count_mul(output int holds, output logic done);
        holds = 0;
        done  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!done) begin
                step(1'b1);
                if (obs_hold_e) holds++;
                if (obs_mul_done) done = 1'b1;
            end
        end
    endtask

    vec_t tbl[14];

    initial begin
        int   h;
        logic d;
        logic raw_eff;
        clk = 1'b0; n_pass = 0; n_total = 0;
        tbl[0]  = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 2'd0, 2'd0};
        tbl[1]  = '{16'h1411, 16'h1123, 16'h0000, 1'b0, 1'b1, 2'd1, 2'd1};
        tbl[2]  = '{16'h1411, 16'h0000, 16'h1123, 1'b0, 1'b1, 2'd2, 2'd2};
        tbl[3]  = '{16'h1412, 16'h1123, 16'h1227, 1'b0, 1'b1, 2'd1, 2'd2};
        tbl[4]  = '{16'h1411, 16'h1123, 16'h1156, 1'b0, 1'b1, 2'd1, 2'd1};
        tbl[5]  = '{16'h3667, 16'h1612, 16'h0000, 1'b0, 1'b0, 2'd0, 2'd0};
        tbl[6]  = '{16'h3667, 16'h1712, 16'h0000, 1'b0, 1'b1, 2'd0, 2'd1};
        tbl[7]  = '{16'h1411, 16'hD123, 16'h0000, 1'b0, 1'b0, 2'd0, 2'd0};
        tbl[8]  = '{16'hD111, 16'h1123, 16'h1123, 1'b0, 1'b0, 2'd0, 2'd0};
        tbl[9]  = '{16'h0111, 16'h1123, 16'h0000, 1'b0, 1'b0, 2'd0, 2'd0};
        tbl[10] = '{16'h1500, 16'h0000, 16'h1034, 1'b0, 1'b1, 2'd2, 2'd2};
        tbl[11] = '{16'h1411, 16'hC123, 16'h0000, 1'b1, 1'b1, 2'd1, 2'd1};
        tbl[12] = '{16'hC512, 16'h1123, 16'h0000, 1'b0, 1'b1, 2'd1, 2'd0};
        tbl[13] = '{16'h7811, 16'h1123, 16'h0000, 1'b0, 1'b1, 2'd0, 2'd1};

        do_reset();
        #1;
        check("reset_stall_cnt", stall_cnt, 0);

        // Static vectors with adv low, so the MUL counter sits at zero
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            ird = tbl[i].d; ire = tbl[i].e; irw = tbl[i].w;
            #1;
            raw_eff = tbl[i].raw && !FWD;
            check($sformatf("vec%0d_hold_fd", i),  hold_fd,  tbl[i].he | raw_eff);
            check($sformatf("vec%0d_hold_e", i),   hold_e,   tbl[i].he);
            check($sformatf("vec%0d_bubble_e", i), bubble_e, raw_eff & !tbl[i].he);
            check($sformatf("vec%0d_bubble_w", i), bubble_w, tbl[i].he);
            check($sformatf("vec%0d_mul_done", i), mul_done, 1'b0);
            check($sformatf("vec%0d_fwd_a", i),    fwd_a,    FWD ? tbl[i].fa : 2'd0);
            check($sformatf("vec%0d_fwd_b", i),    fwd_b,    FWD ? tbl[i].fb : 2'd0);
        end

        // ADD r1,r2,r3 then ADD r4,r1,r1, then a writeback-distance consumer
        do_reset();
        ire = 16'h1123; ird = 16'h1411; fetch_q.push_back(16'h1511);
        repeat (4) step(1'b1);
        check("raw_seq_stall_cnt", stall_cnt, FWD ? 32'd0 : 32'd2);

        // MUL latency followed by a back-to-back MUL
        do_reset();
        ire = 16'hC523; ird = 16'hC612;
        count_mul(h, d);
        check("mul_holds", h, MUL_LAT - 1);
        check("mul_done_seen", d, 1'b1);
        count_mul(h, d);
        check("mul_b2b_holds", h, MUL_LAT - 1);
        check("mul_b2b_done_seen", d, 1'b1);

        // Reset pulse mid-MUL with a dependent instruction waiting in decode
        do_reset();
        ire = 16'hC523; ird = 16'h1755;
        step(1'b1);
        step(1'b1);
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        mul_age = 0; stall_m = 0;
        #1;
        check("midmul_reset_stall_cnt", stall_cnt, 0);
        count_mul(h, d);
        check("mul_after_reset_holds", h, MUL_LAT - 1);
        check("mul_after_reset_done", d, 1'b1);

        // adv held low for 10 clocks during a MUL
        do_reset();
        ire = 16'hC523;
        step(1'b1);
        repeat (10) step(1'b0);
        check("adv_low_stall_cnt", stall_cnt, 1);
        count_mul(h, d);
        check("mul_resume_holds", h, MUL_LAT - 2);
        check("mul_resume_done", d, 1'b1);

        // Random instruction stream with random advance
        do_reset();
        rand_mode = 1'b1;
        ird = rnd_instr(); ire = rnd_instr(); irw = rnd_instr();
        for (int i = 0; i < 400; i++) step($urandom_range(0, 3) != 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
